l1_wb_cache: RTL

Parametrised N-way set-associative L1 data cache. It is write-back and write-allocate, uses true-LRU replacement and tracks a dirty bit per line. It sits between the CPU load/store port and the L2 cache, and exchanges whole blocks with L2 over a flattened block bus. It exports hit, miss and write-back event counters for performance monitoring.

---
 rtl/l1_wb_cache_if.sv | 36 +++
 rtl/l1_wb_cache.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/l1_wb_cache_if.sv
// l1_wb_cache_if: bundles the CPU load/store port and the L2 block port of the
// L1 write-back cache.
//   cpu_addr/cpu_data_in/cpu_read/cpu_write : request from the CPU
//   cpu_data_out/cpu_ready/cpu_hit          : one-cycle completion to the CPU
//   l2_addr/l2_data_out/l2_read/l2_write    : level-held block request to L2
//   l2_data_in/l2_ready                     : fill data and completion from L2
// Modport slave is the cache's view; modport master is the CPU+L2 side.
interface l1_wb_cache_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned BLOCK_WORDS = 4
);
   logic [ADDR_WIDTH-1:0]             cpu_addr;
   logic [DATA_WIDTH-1:0]             cpu_data_in;
   logic                              cpu_read;
   logic                              cpu_write;
   logic [DATA_WIDTH-1:0]             cpu_data_out;
   logic                              cpu_ready;
   logic                              cpu_hit;
   logic [ADDR_WIDTH-1:0]             l2_addr;
   logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_data_out;
   logic [BLOCK_WORDS*DATA_WIDTH-1:0] l2_data_in;
   logic                              l2_read;
   logic                              l2_write;
   logic                              l2_ready;

   modport slave (
      input  cpu_addr, cpu_data_in, cpu_read, cpu_write, l2_data_in, l2_ready,
      output cpu_data_out, cpu_ready, cpu_hit, l2_addr, l2_data_out, l2_read, l2_write
   );

   modport master (
      output cpu_addr, cpu_data_in, cpu_read, cpu_write, l2_data_in, l2_ready,
      input  cpu_data_out, cpu_ready, cpu_hit, l2_addr, l2_data_out, l2_read, l2_write
   );
endinterface

// File: rtl/l1_wb_cache.sv
// l1_wb_cache: N-way set-associative, write-back / write-allocate L1 data
// cache with true-LRU replacement and per-line dirty bits.
//   clk, rst   : single rising-edge clock, synchronous active-high reset
//   bus        : l1_wb_cache_if.slave (CPU request/response, L2 block bus)
//   hit_count, miss_count, wb_count : saturating event counters
module l1_wb_cache #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned NUM_SETS    = 16,
   parameter int unsigned NUM_WAYS    = 4,
   parameter int unsigned BLOCK_WORDS = 4,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   l1_wb_cache_if.slave         bus,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count,
   output logic [CNT_WIDTH-1:0] wb_count
);
   localparam int unsigned OW = $clog2(BLOCK_WORDS);
   localparam int unsigned IW = $clog2(NUM_SETS);
   localparam int unsigned AW = $clog2(NUM_WAYS);
   localparam int unsigned TW = ADDR_WIDTH - OW - IW;

   typedef logic [BLOCK_WORDS-1:0][DATA_WIDTH-1:0] line_t;
   typedef logic [NUM_WAYS-1:0][AW-1:0]            ages_t;
   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, DONE} state_t;

   state_t state, state_nxt;

   logic [NUM_WAYS-1:0] valid    [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty    [NUM_SETS];
   ages_t               age      [NUM_SETS];
   logic [TW-1:0]       tag_mem  [NUM_SETS][NUM_WAYS];
   line_t               data_mem [NUM_SETS][NUM_WAYS];

   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  req_write;
   logic [AW-1:0]         victim;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  hit_flag;
   logic                  l2_rd;
   logic                  l2_wr;

   logic [OW-1:0] req_off;
   logic [IW-1:0] req_idx;
   logic [TW-1:0] req_tag;
   assign req_off = req_addr[OW-1:0];
   assign req_idx = req_addr[OW +: IW];
   assign req_tag = req_addr[ADDR_WIDTH-1 -: TW];

   // Accessed way becomes youngest; every way younger than it ages by one,
   // so the ages stay a permutation of 0..NUM_WAYS-1.
   function automatic ages_t lru_touch(input ages_t cur, input logic [AW-1:0] way);
      ages_t upd;
      upd = cur;
      for (int unsigned i = 0; i < NUM_WAYS; i++)
         if (cur[i] < cur[way]) upd[i] = cur[i] + 1'b1;
      upd[way] = '0;
      return upd;
   endfunction

   logic          hit;
   logic [AW-1:0] hit_way;
   logic [AW-1:0] victim_sel;
   logic          victim_found;

   always_comb begin
      hit          = 1'b0;
      hit_way      = '0;
      victim_sel   = '0;
      victim_found = 1'b0;
      for (int unsigned i = 0; i < NUM_WAYS; i++) begin
         if (valid[req_idx][i] && tag_mem[req_idx][i] == req_tag) begin
            hit     = 1'b1;
            hit_way = AW'(i);
         end
         if (!victim_found && !valid[req_idx][i]) begin
            victim_found = 1'b1;
            victim_sel   = AW'(i);
         end
      end
      if (!victim_found)
         for (int unsigned i = 0; i < NUM_WAYS; i++)
            if (age[req_idx][i] == AW'(NUM_WAYS - 1)) victim_sel = AW'(i);
   end

   line_t fill_line;
   always_comb begin
      fill_line = bus.l2_data_in;
      if (req_write) fill_line[req_off] = req_data;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (bus.cpu_read || bus.cpu_write) state_nxt = LOOKUP;
         LOOKUP: begin
            if (hit)
               state_nxt = DONE;
            else if (valid[req_idx][victim_sel] && dirty[req_idx][victim_sel])
               state_nxt = WRITEBACK;
            else
               state_nxt = FILL;
         end
         WRITEBACK: if (l2_wr && bus.l2_ready) state_nxt = FILL;
         FILL:      if (l2_rd && bus.l2_ready) state_nxt = DONE;
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned s = 0; s < NUM_SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            for (int unsigned i = 0; i < NUM_WAYS; i++) age[s][i] <= AW'(i);
         end
         req_addr   <= '0;
         req_data   <= '0;
         req_write  <= 1'b0;
         victim     <= '0;
         data_out   <= '0;
         hit_flag   <= 1'b0;
         l2_rd      <= 1'b0;
         l2_wr      <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         // Request strobes rise one cycle after entering their state and fall
         // right after the accepting l2_ready, so L2 only ever sees stable
         // address/data while a strobe is high.
         l2_rd <= (state == FILL) && (state_nxt == FILL);
         l2_wr <= (state == WRITEBACK) && (state_nxt == WRITEBACK);
         case (state)
            IDLE: begin
               if (bus.cpu_read || bus.cpu_write) begin
                  req_addr  <= bus.cpu_addr;
                  req_data  <= bus.cpu_data_in;
                  req_write <= bus.cpu_write;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  age[req_idx] <= lru_touch(age[req_idx], hit_way);
                  hit_flag     <= 1'b1;
                  if (hit_count != '1) hit_count <= hit_count + 1'b1;
                  if (req_write) begin
                     data_mem[req_idx][hit_way][req_off] <= req_data;
                     dirty[req_idx][hit_way]             <= 1'b1;
                     data_out                            <= req_data;
                  end else begin
                     data_out <= data_mem[req_idx][hit_way][req_off];
                  end
               end else begin
                  victim <= victim_sel;
                  if (miss_count != '1) miss_count <= miss_count + 1'b1;
               end
            end
            WRITEBACK: begin
               if (l2_wr && bus.l2_ready && wb_count != '1) wb_count <= wb_count + 1'b1;
            end
            FILL: begin
               if (l2_rd && bus.l2_ready) begin
                  data_mem[req_idx][victim] <= fill_line;
                  tag_mem[req_idx][victim]  <= req_tag;
                  valid[req_idx][victim]    <= 1'b1;
                  dirty[req_idx][victim]    <= req_write;
                  age[req_idx]              <= lru_touch(age[req_idx], victim);
                  data_out                  <= fill_line[req_off];
                  hit_flag                  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cpu_data_out = data_out;
   assign bus.cpu_hit      = hit_flag;
   assign bus.cpu_ready    = (state == DONE);
   assign bus.l2_read      = l2_rd;
   assign bus.l2_write     = l2_wr;
   assign bus.l2_addr      = l2_rd ? {req_tag, req_idx, {OW{1'b0}}} :
                             l2_wr ? {tag_mem[req_idx][victim], req_idx, {OW{1'b0}}} : '0;
   assign bus.l2_data_out  = l2_wr ? data_mem[req_idx][victim] : '0;
endmodule
